// File: rtl/click_sub_scheduler.sv
// Shared-subtractor scheduler for NREQ click-style requesters.
// Input requests and the output acknowledge are 2-phase toggles from
// asynchronous logic. Each passes through a 2-flop synchroniser before use.
// Requesters are granted round-robin. Each grant occupies the subtractor for
// max(delay_cfg,1) cycles. The result is then presented on a single 2-phase
// output channel. The requester is acknowledged only once that output
// transfer has completed.
module click_sub_scheduler #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 12,
  parameter int SRC_W = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       in_req,
  input  logic [NREQ*WIDTH-1:0] in_a,
  input  logic [NREQ*WIDTH-1:0] in_b,
  output logic [NREQ-1:0]       in_ack,
  input  logic [3:0]            delay_cfg,
  output logic                  out_req,
  input  logic                  out_ack,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_borrow,
  output logic [SRC_W-1:0]      out_src,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, BUSY, WAIT_OUT} state_e;

  state_e                    state_q;
  logic [NREQ-1:0]           req_s1_q, req_s_q, in_ack_q;
  logic                      oack_s1_q, oack_s_q;
  logic [SRC_W-1:0]          ptr_q, sel_q;
  logic [3:0]                cnt_q;
  logic [WIDTH-1:0]          a_q, b_q;
  logic                      out_req_q, out_borrow_q, busy_q;
  logic [WIDTH-1:0]          out_data_q;
  logic [SRC_W-1:0]          out_src_q;

  logic [NREQ-1:0]           pending;
  logic [NREQ-1:0][WIDTH-1:0] a_arr, b_arr;
  logic                      gnt_vld_d;
  logic [SRC_W-1:0]          gnt_d;
  logic [WIDTH-1:0]          diff_d;
  logic                      borrow_d;

  // Unpack the flat operand buses into per-requester lanes.
  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    assign a_arr[i] = in_a[i*WIDTH +: WIDTH];
    assign b_arr[i] = in_b[i*WIDTH +: WIDTH];
  end

  // A request is outstanding while its synchronised toggle differs from our ack.
  assign pending = req_s_q ^ in_ack_q;

  // Round-robin pick: the lowest offset from ptr that is pending wins.
  always_comb begin
    int idx;
    gnt_vld_d = 1'b0;
    gnt_d     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (pending[idx]) begin
        gnt_vld_d = 1'b1;
        gnt_d     = SRC_W'(idx);
      end
    end
  end

  // The extra MSB of the widened subtraction is the unsigned borrow.
  always_comb begin
    {borrow_d, diff_d} = {1'b0, a_q} - {1'b0, b_q};
  end

  // Two-flop synchronisers for the asynchronous toggle inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_s1_q  <= '0;
      req_s_q   <= '0;
      oack_s1_q <= 1'b0;
      oack_s_q  <= 1'b0;
    end else begin
      req_s1_q  <= in_req;
      req_s_q   <= req_s1_q;
      oack_s1_q <= out_ack;
      oack_s_q  <= oack_s1_q;
    end
  end

  // Scheduler FSM: grant, model the subtractor delay, then hand off and ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      sel_q        <= '0;
      cnt_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      in_ack_q     <= '0;
      out_req_q    <= 1'b0;
      out_data_q   <= '0;
      out_borrow_q <= 1'b0;
      out_src_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_vld_d) begin
            sel_q   <= gnt_d;
            a_q     <= a_arr[gnt_d];
            b_q     <= b_arr[gnt_d];
            cnt_q   <= (delay_cfg == 4'd0) ? 4'd1 : delay_cfg;
            state_q <= BUSY;
            busy_q  <= 1'b1;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            out_data_q   <= diff_d;
            out_borrow_q <= borrow_d;
            out_src_q    <= sel_q;
            out_req_q    <= ~out_req_q;
            state_q      <= WAIT_OUT;
          end
        end
        WAIT_OUT: begin
          if (oack_s_q == out_req_q) begin
            in_ack_q[sel_q] <= ~in_ack_q[sel_q];
            ptr_q   <= (sel_q == SRC_W'(NREQ - 1)) ? '0 : sel_q + SRC_W'(1);
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ack     = in_ack_q;
  assign out_req    = out_req_q;
  assign out_data   = out_data_q;
  assign out_borrow = out_borrow_q;
  assign out_src    = out_src_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_click_sub_scheduler.sv
// Directed bench for click_sub_scheduler: latency, wrap arithmetic,
// round-robin order, output backpressure and reset mid-operation.
module tb_click_sub_scheduler;
  localparam int NREQ = 4, WIDTH = 12, SRC_W = 2;

  logic                  clk = 1'b0, reset = 1'b0;
  logic [NREQ-1:0]       in_req = '0;
  logic [NREQ*WIDTH-1:0] in_a = '0, in_b = '0;
  logic [NREQ-1:0]       in_ack;
  logic [3:0]            delay_cfg = 4'd1;
  logic                  out_req, out_ack = 1'b0;
  logic [WIDTH-1:0]      out_data;
  logic                  out_borrow;
  logic [SRC_W-1:0]      out_src;
  logic                  busy;

  int   cyc = 0, n_chk = 0, n_err = 0;
  logic oreq_lvl = 1'b0;

  click_sub_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .SRC_W(SRC_W)) dut (
    .clk(clk), .reset(reset), .in_req(in_req), .in_a(in_a), .in_b(in_b),
    .in_ack(in_ack), .delay_cfg(delay_cfg), .out_req(out_req), .out_ack(out_ack),
    .out_data(out_data), .out_borrow(out_borrow), .out_src(out_src), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic set_op(input int i, input int a, input int b);
    in_a[i*WIDTH +: WIDTH] = WIDTH'(a);
    in_b[i*WIDTH +: WIDTH] = WIDTH'(b);
  endtask

  task automatic do_reset();
    reset = 1'b0; in_req = '0; out_ack = 1'b0; oreq_lvl = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_busy(input string tag, output int t);
    int n = 0;
    while (busy !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk({tag, "_grant_seen"}, 32'(n < 100), 1);
    t = cyc;
  endtask

  // Wait for the result, check it, hold the ack for ack_dly cycles while
  // checking the result is held, then ack and wait for the requester ack.
  task automatic serve(input string tag, input int src, input int data, input int brw,
                       input int ack_dly, output int t_o, output int ack_lat);
    int n = 0;
    int t_a;
    logic [NREQ-1:0] ack0;
    while (out_req === oreq_lvl && n < 200) begin @(negedge clk); n++; end
    chk({tag, "_oreq_seen"}, 32'(n < 200), 1);
    oreq_lvl = ~oreq_lvl;
    t_o  = cyc;
    ack0 = in_ack;
    chk({tag, "_data"},   32'(out_data),   data);
    chk({tag, "_borrow"}, 32'(out_borrow), brw);
    chk({tag, "_src"},    32'(out_src),    src);
    for (int k = 0; k < ack_dly; k++) begin
      @(negedge clk);
      chk({tag, "_hold"}, {busy, out_req, 2'(out_src), out_borrow, in_ack, 12'(out_data)},
          {1'b1, oreq_lvl, 2'(src), 1'(brw), ack0, 12'(data)});
    end
    out_ack = ~out_ack;
    t_a = cyc;
    n = 0;
    while (in_ack === ack0 && n < 50) begin @(negedge clk); n++; end
    chk({tag, "_inack"}, 32'(in_ack), 32'(ack0 ^ (NREQ'(1) << src)));
    ack_lat = cyc - t_a;
  endtask

  initial begin
    int t0, tg, to, al;
    // Reset and idle
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("idle_outs", {in_ack, out_req, out_data, out_borrow, out_src, busy}, 0);
    end

    // Single request 0, delay 3
    set_op(0, 100, 37); delay_cfg = 4'd3;
    t0 = cyc; in_req[0] = ~in_req[0];
    wait_busy("r0", tg);
    chk("r0_grant_lat", tg - t0, 3);
    serve("r0", 0, 63, 0, 2, to, al);
    chk("r0_oreq_lat", to - tg, 3);
    chk("r0_ack_lat", al, 3);
    repeat (5) @(negedge clk);
    chk("r0_ack_once", 32'(in_ack), 32'b0001);

    // Request 2, delay 0 behaves as 1, wrapping subtraction
    set_op(2, 5, 9); delay_cfg = 4'd0;
    in_req[2] = ~in_req[2];
    wait_busy("r2", tg);
    serve("r2", 2, 4092, 1, 2, to, al);
    chk("r2_oreq_lat", to - tg, 1);

    // All four at once, round-robin from ptr 0
    do_reset();
    delay_cfg = 4'd2;
    for (int i = 0; i < NREQ; i++) set_op(i, i*10 + 20, i);
    in_req = 4'b1111;
    serve("rr0", 0, 20, 0, 1, to, al);
    serve("rr1", 1, 29, 0, 1, to, al);
    serve("rr2", 2, 38, 0, 1, to, al);
    serve("rr3", 3, 47, 0, 1, to, al);
    in_req = in_req ^ 4'b1001;
    serve("rr4", 0, 20, 0, 1, to, al);
    serve("rr5", 3, 47, 0, 1, to, al);
    in_req = in_req ^ 4'b1010;
    serve("rr6", 1, 29, 0, 1, to, al);
    serve("rr7", 3, 47, 0, 1, to, al);

    // Backpressure: out_ack withheld 25 cycles while req1 waits
    set_op(2, 7, 3); set_op(1, 1, 2); delay_cfg = 4'd4;
    in_req[2] = ~in_req[2];
    wait_busy("bp", tg);
    in_req[1] = ~in_req[1];
    serve("bp2", 2, 4, 0, 25, to, al);
    serve("bp1", 1, 4095, 1, 1, to, al);

    // Reset during BUSY of requester 1
    do_reset();
    set_op(1, 300, 45); delay_cfg = 4'd15;
    in_req = 4'b0010;
    wait_busy("rst", tg);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0; out_ack = 1'b0; oreq_lvl = 1'b0;
    #1 chk("rst_outs", {in_ack, out_req, out_data, out_borrow, out_src, busy}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wait_busy("rst_re", tg);
    serve("rst1", 1, 255, 0, 2, to, al);
    chk("rst1_oreq_lat", to - tg, 15);
    chk("rst1_inack_final", 32'(in_ack), 32'b0010);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
